// File: rtl/sram_data_responder_pkg.sv
// Shared constants and helpers for the data-SRAM responder: config window offsets
// and the byte-lane merge used by every byte-writable register.
package sram_data_responder_pkg;

  localparam logic [15:0] CONF_LED_OFF   = 16'h0000;
  localparam logic [15:0] CONF_SW_OFF    = 16'h0004;
  localparam logic [15:0] CONF_COUNT_OFF = 16'h0008;
  localparam logic [15:0] CONF_CMP_OFF   = 16'h000C;
  localparam logic [15:0] CONF_STAT_OFF  = 16'h0010;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sram_data_responder_if.sv
// Core data-SRAM port bundle; the core is master, the responder is slave.
interface sram_data_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/sram_data_responder_conf_timer.sv
// Free-running COUNT with COMPARE match; pending latches on the match and is
// cleared by writing 1 to STATUS bit0, the match taking priority.
module sram_data_responder_conf_timer
  import sram_data_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic [3:0]  wen,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        stat_we,
  output logic [31:0] count_q,
  output logic [31:0] compare_q,
  output logic        pending_q
);

  logic [31:0] count_d, compare_d;
  logic        pending_d;

  always_comb begin
    count_d   = count_we ? byte_merge(count_q, wdata, wen) : count_q + 32'd1;
    compare_d = cmp_we ? byte_merge(compare_q, wdata, wen) : compare_q;
    pending_d = pending_q;
    if (stat_we && wen[0] && wdata[0]) pending_d = 1'b0;
    // Match is judged on the value COUNT is about to take.
    if (count_d == compare_q) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/sram_data_responder.sv
// Data-SRAM slave: byte-writable RAM plus LED/SW/timer config window, 1-cycle reads.
// Timer registers and timer_int exist only when CONF_TIMER_EN is defined.
module sram_data_responder
  import sram_data_responder_pkg::*;
#(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] CONF_HI = 16'hBFAF,
  parameter int          LED_W   = 16,
  parameter int          SW_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_data_responder_if.slave bus,
  output logic [LED_W-1:0]     led,
  input  logic [SW_W-1:0]      sw,
  output logic                 timer_int
);

  localparam int NUM_LANES = 4;

  logic              conf, rd, wr;
  logic [15:0]       off;
  logic [ADDR_W-1:0] idx;

  assign conf = (bus.addr[31:16] == CONF_HI);
  assign off  = bus.addr[15:0];
  assign idx  = bus.addr[ADDR_W+1:2];
  assign rd   = bus.en && (bus.wen == 4'b0000);
  assign wr   = bus.en && (bus.wen != 4'b0000);

  // One byte-wide array per lane so each lane infers its own write enable.
  logic [NUM_LANES-1:0][7:0] ram_rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (!rst && wr && !conf && bus.wen[i]) mem[idx] <= bus.wdata[8*i +: 8];
      if (!rst && rd && !conf) rd_q <= mem[idx];
    end

    assign ram_rdata[i] = rd_q;
  end

`ifdef CONF_TIMER_EN
  logic [31:0] count, compare;
  logic        pending;

  sram_data_responder_conf_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .wdata     (bus.wdata),
    .wen       (bus.wen),
    .count_we  (wr && conf && off == CONF_COUNT_OFF),
    .cmp_we    (wr && conf && off == CONF_CMP_OFF),
    .stat_we   (wr && conf && off == CONF_STAT_OFF),
    .count_q   (count),
    .compare_q (compare),
    .pending_q (pending)
  );

  assign timer_int = pending;
`else
  assign timer_int = 1'b0;
`endif

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      led_merged, conf_val;
  logic [31:0]      conf_rdata_q, conf_rdata_d;
  logic             sel_conf_q, sel_conf_d;

  always_comb begin
    led_merged = byte_merge(32'(led_q), bus.wdata, bus.wen);
    led_d      = led_q;
    if (wr && conf && off == CONF_LED_OFF) led_d = led_merged[LED_W-1:0];

    conf_val = 32'd0;
    case (off)
      CONF_LED_OFF:   conf_val = 32'(led_q);
      CONF_SW_OFF:    conf_val = 32'(sw);
`ifdef CONF_TIMER_EN
      CONF_COUNT_OFF: conf_val = count;
      CONF_CMP_OFF:   conf_val = compare;
      CONF_STAT_OFF:  conf_val = {31'd0, pending};
`endif
      default:        conf_val = 32'd0;
    endcase

    // Read source is remembered so rdata holds across idle and write cycles.
    sel_conf_d   = sel_conf_q;
    conf_rdata_d = conf_rdata_q;
    if (rd) begin
      sel_conf_d = conf;
      if (conf) conf_rdata_d = conf_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q        <= '0;
      sel_conf_q   <= 1'b1;
      conf_rdata_q <= 32'd0;
    end else begin
      led_q        <= led_d;
      sel_conf_q   <= sel_conf_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  assign led       = led_q;
  assign bus.rdata = sel_conf_q ? conf_rdata_q : ram_rdata;

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed self-checking bench for sram_data_responder; timer steps follow CONF_TIMER_EN.
module tb_sram_data_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] led;
  logic [7:0]  sw;
  logic        timer_int;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sram_data_responder_if bus ();

  sram_data_responder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .sw        (sw),
    .timer_int (timer_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.en = 1'b1; bus.wen = w; bus.addr = a; bus.wdata = d;
    tick();
    bus.en = 1'b0; bus.wen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.en = 1'b1; bus.wen = 4'b0000; bus.addr = a;
    tick();
    bus.en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00;
    bus.en = 1'b0; bus.wen = 4'b0000; bus.addr = 32'd0; bus.wdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_timer_int", 32'(timer_int), 32'd0);

    wr(32'h0000_0040, 32'h1234_5678, 4'b1111);
    check("rdata_hold_on_write", bus.rdata, 32'd0);
    rd(32'h0000_0040);
    check("ram_full_word", bus.rdata, 32'h1234_5678);
    tick();
    check("rdata_hold_idle", bus.rdata, 32'h1234_5678);

    wr(32'h0000_0040, 32'hAABB_CCDD, 4'b0101);
    check("rdata_hold_on_partial_write", bus.rdata, 32'h1234_5678);
    rd(32'h0000_0040);
    check("ram_byte_merge", bus.rdata, 32'h12BB_56DD);
    rd(32'h0001_0040);
    check("ram_alias", bus.rdata, 32'h12BB_56DD);

    wr(32'hBFAF_0000, 32'h0000_FFFF, 4'b1111);
    check("led_write", 32'(led), 32'h0000_FFFF);
    wr(32'hBFAF_0000, 32'h0000_1200, 4'b0010);
    check("led_byte_write", 32'(led), 32'h0000_12FF);
    rd(32'hBFAF_0000);
    check("led_readback", bus.rdata, 32'h0000_12FF);
    sw = 8'hA5;
    rd(32'hBFAF_0004);
    check("sw_read", bus.rdata, 32'h0000_00A5);
    wr(32'hBFAF_0004, 32'h0000_0000, 4'b1111);
    rd(32'hBFAF_0004);
    check("sw_write_ignored", bus.rdata, 32'h0000_00A5);
    rd(32'hBFAF_0020);
    check("unmapped_read", bus.rdata, 32'd0);

`ifdef CONF_TIMER_EN
    wr(32'hBFAF_000C, 32'd100, 4'b1111);
    wr(32'hBFAF_0008, 32'd90, 4'b1111);
    rd(32'hBFAF_0008);
    check("count_read", bus.rdata, 32'd90);
    repeat (8) tick();
    check("timer_before_match", 32'(timer_int), 32'd0);
    tick();
    check("timer_at_match", 32'(timer_int), 32'd1);
    rd(32'hBFAF_0010);
    check("status_read", bus.rdata, 32'd1);
    wr(32'hBFAF_0010, 32'd1, 4'b1111);
    check("w1c_clear", 32'(timer_int), 32'd0);
    wr(32'hBFAF_0008, 32'd97, 4'b1111);
    tick(); tick();
    wr(32'hBFAF_0010, 32'd1, 4'b1111);
    check("set_wins_over_w1c", 32'(timer_int), 32'd1);
    wr(32'hBFAF_0010, 32'd1, 4'b1111);
    check("w1c_clear_again", 32'(timer_int), 32'd0);
    rd(32'hBFAF_000C);
    check("compare_read", bus.rdata, 32'd100);
    wr(32'hBFAF_0008, 32'hFFFF_FFFE, 4'b1111);
    tick(); tick();
    rd(32'hBFAF_0008);
    check("count_wrap", bus.rdata, 32'd0);
`else
    wr(32'hBFAF_0008, 32'h0000_1234, 4'b1111);
    rd(32'hBFAF_0008);
    check("count_absent", bus.rdata, 32'd0);
    wr(32'hBFAF_000C, 32'd5, 4'b1111);
    rd(32'hBFAF_000C);
    check("compare_absent", bus.rdata, 32'd0);
    rd(32'hBFAF_0010);
    check("status_absent", bus.rdata, 32'd0);
    check("timer_int_tied", 32'(timer_int), 32'd0);
`endif

    rd(32'h0000_0040);
    bus.en = 1'b1; bus.wen = 4'b1111; bus.addr = 32'h0000_0040; bus.wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.en = 1'b0; bus.wen = 4'b0000;
    check("rst_mid_rdata", bus.rdata, 32'd0);
    check("rst_mid_led", 32'(led), 32'd0);
    check("rst_mid_timer_int", 32'(timer_int), 32'd0);
    rd(32'h0000_0040);
    check("rst_write_dropped", bus.rdata, 32'h12BB_56DD);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
